fetch_sequencer: RTL

- Program-counter and fetch controller for the 10-bit instruction ROM (1024 x 10-bit, combinational read).
- Drives the ROM address and presents each instruction word to the decoder over a valid/ready handshake.
- Applies branch/jump redirects from execute, detects the halt word, and counts fetched instructions.
- Sits between the instruction ROM and the core's decode stage.

---
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch controller for a 1024 x 10-bit
// combinational instruction ROM. Presents each ROM word to decode over a
// valid/ready handshake, applies execute redirects, stops on the halt word
// and counts accepted fetches (saturating).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse: begin/restart execution (IDLE or HALT only)
//   rom_addr/rom_data ROM address out, same-cycle read data in
//   instr_data/pc     word and its PC presented to decode
//   instr_valid/ready decode handshake
//   redirect_valid/pc execute PC change (absolute target)
//   halted, running   FSM status
//   pc_wrap           sticky: sequential PC increment wrapped to 0
//   fetch_count       accepted fetches, saturating
//
// Optional feature, macro FETCH_BREAKPOINT_EN: adds bp_en, bp_addr, bp_hit.
// A breakpoint halts before fetching the word at bp_addr; the next start
// resumes at bp_addr with the compare suppressed for that first fetch.
module fetch_sequencer #(
  parameter int AW = 10,
  parameter int DW = 10,
  parameter logic [AW-1:0] RESET_PC = 10'd0,
  parameter logic [DW-1:0] HALT_WORD = 10'b0010000010,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] instr_data,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          halted,
  output logic          running,
  output logic          pc_wrap,
  output logic [CW-1:0] fetch_count
`ifdef FETCH_BREAKPOINT_EN
  ,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  output logic          bp_hit
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic          in_run;
  logic          bp_stop;

  assign in_run     = (state == RUN);
  assign rom_addr   = pc;
  assign instr_data = rom_data;
  assign instr_pc   = pc;

`ifdef FETCH_BREAKPOINT_EN
  logic bp_skip;  // set on resume from a breakpoint so it does not re-trigger
  // A redirect discards the current word anyway, so it takes precedence.
  assign bp_stop = in_run && !redirect_valid && bp_en && (pc == bp_addr) && !bp_skip;
`else
  assign bp_stop = 1'b0;
`endif

  // Bubble during a redirect; otherwise valid for the whole RUN state.
  assign instr_valid = in_run && !redirect_valid && !bp_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      running     <= 1'b0;
      pc_wrap     <= 1'b0;
      fetch_count <= '0;
`ifdef FETCH_BREAKPOINT_EN
      bp_hit      <= 1'b0;
      bp_skip     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
            pc      <= RESET_PC;
          end
        end
        RUN: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
`ifdef FETCH_BREAKPOINT_EN
            bp_skip <= 1'b0;
`endif
          end else if (bp_stop) begin
            state   <= HALT;
            running <= 1'b0;
            halted  <= 1'b1;
`ifdef FETCH_BREAKPOINT_EN
            bp_hit  <= 1'b1;
`endif
          end else if (instr_ready) begin
            if (fetch_count != {CW{1'b1}}) fetch_count <= fetch_count + CW'(1);
`ifdef FETCH_BREAKPOINT_EN
            bp_skip <= 1'b0;
`endif
            if (rom_data == HALT_WORD) begin
              // pc keeps pointing at the halt word
              state   <= HALT;
              running <= 1'b0;
              halted  <= 1'b1;
            end else begin
              pc <= pc + AW'(1);
              if (pc == {AW{1'b1}}) pc_wrap <= 1'b1;
            end
          end
        end
        HALT: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
            halted  <= 1'b0;
`ifdef FETCH_BREAKPOINT_EN
            // Resume at the breakpoint address (pc already holds it).
            pc      <= bp_hit ? pc : RESET_PC;
            bp_skip <= bp_hit;
            bp_hit  <= 1'b0;
`else
            pc      <= RESET_PC;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule
